muldiv_issue_ctrl: RTL and testbench



---
 rtl/muldiv_issue_ctrl_if.sv | 48 ++++
 rtl/muldiv_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_muldiv_issue_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_issue_ctrl_if.sv
// Handshake bundle between the EXU pipeline, the iterative mul/div unit and writeback.
// slave = issue controller view; master = surrounding pipeline/unit/writeback view.
interface muldiv_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             op_valid;
    logic             op_ready;
    logic [2:0]       op_funct3;
    logic             op_is_w;
    logic [63:0]      op_rs1;
    logic [63:0]      op_rs2;
    logic [TAG_W-1:0] op_rd;
    logic             flush;
    logic             mul_valid;
    logic             div_valid;
    logic             muldivw;
    logic [1:0]       mul_signed;
    logic             div_signed;
    logic [63:0]      muldiv_rs1;
    logic [63:0]      muldiv_rs2;
    logic             muldiv_flush;
    logic             muldiv_ready;
    logic             out_valid;
    logic [63:0]      result_hi;
    logic [63:0]      result_lo;
    logic [63:0]      quotient;
    logic [63:0]      remainder;
    logic             wb_valid;
    logic             wb_ready;
    logic [63:0]      wb_data;
    logic [TAG_W-1:0] wb_rd;

    modport slave (
        input  op_valid, op_funct3, op_is_w, op_rs1, op_rs2, op_rd, flush,
        input  muldiv_ready, out_valid, result_hi, result_lo, quotient, remainder,
        input  wb_ready,
        output op_ready, mul_valid, div_valid, muldivw, mul_signed, div_signed,
        output muldiv_rs1, muldiv_rs2, muldiv_flush, wb_valid, wb_data, wb_rd
    );

    modport master (
        output op_valid, op_funct3, op_is_w, op_rs1, op_rs2, op_rd, flush,
        output muldiv_ready, out_valid, result_hi, result_lo, quotient, remainder,
        output wb_ready,
        input  op_ready, mul_valid, div_valid, muldivw, mul_signed, div_signed,
        input  muldiv_rs1, muldiv_rs2, muldiv_flush, wb_valid, wb_data, wb_rd
    );
endinterface

// File: rtl/muldiv_issue_ctrl.sv
// RV64M issue controller: decodes one op, starts the iterative unit or resolves
// divide-by-zero / signed overflow locally, and holds the sign-extended result for writeback.
module muldiv_issue_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    muldiv_issue_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;

    state_t           r_state;
    logic [2:0]       r_funct3;
    logic             r_is_w;
    logic [63:0]      r_rs1;
    logic [63:0]      r_rs2;
    logic [TAG_W-1:0] r_rd;
    logic [1:0]       r_mul_signed;
    logic             r_div_signed;
    logic [63:0]      r_wb_data;

    logic [2:0]       w_f3_eff;
    logic             w_rs2_zero;
    logic             w_min_neg1;
    logic             w_div_zero;
    logic             w_sgn_ovf;
    logic             w_special;
    logic [63:0]      w_special_data;
    logic [63:0]      w_unit_data;
    logic [63:0]      w_div_sel;
    logic             w_fire;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Any W op in the multiply group collapses to MULW, covering illegal MULHW-style encodings.
    assign w_f3_eff   = (bus.op_is_w && !bus.op_funct3[2]) ? 3'b000 : bus.op_funct3;
    assign w_rs2_zero = bus.op_is_w ? (bus.op_rs2[31:0] == 32'h0) : (bus.op_rs2 == 64'h0);
    assign w_min_neg1 = bus.op_is_w
                      ? (bus.op_rs1[31:0] == 32'h8000_0000 && bus.op_rs2[31:0] == 32'hFFFF_FFFF)
                      : (bus.op_rs1 == {1'b1, 63'h0} && bus.op_rs2 == {64{1'b1}});
    assign w_div_zero = w_f3_eff[2] & w_rs2_zero;
    assign w_sgn_ovf  = w_f3_eff[2] & ~w_f3_eff[0] & w_min_neg1;
    assign w_special  = w_div_zero | w_sgn_ovf;

    always_comb begin
        w_special_data = 64'h0;
        if (w_div_zero) begin
            if (w_f3_eff[1])
                w_special_data = bus.op_is_w ? sext32(bus.op_rs1[31:0]) : bus.op_rs1;
            else
                w_special_data = {64{1'b1}};
        end else if (w_sgn_ovf && !w_f3_eff[1]) begin
            w_special_data = bus.op_is_w ? sext32(32'h8000_0000) : bus.op_rs1;
        end
    end

    assign w_div_sel = r_funct3[1] ? bus.remainder : bus.quotient;

    always_comb begin
        w_unit_data = 64'h0;
        if (r_funct3[2])
            w_unit_data = r_is_w ? sext32(w_div_sel[31:0]) : w_div_sel;
        else if (r_funct3[1:0] == 2'b00)
            w_unit_data = r_is_w ? sext32(bus.result_lo[31:0]) : bus.result_lo;
        else
            w_unit_data = bus.result_hi;
    end

    assign w_fire = (r_state == S_ISSUE) & bus.muldiv_ready & ~bus.flush;

    assign bus.op_ready     = (r_state == S_IDLE) & ~bus.flush;
    assign bus.mul_valid    = w_fire & ~r_funct3[2];
    assign bus.div_valid    = w_fire & r_funct3[2];
    assign bus.muldivw      = r_is_w;
    assign bus.mul_signed   = r_mul_signed;
    assign bus.div_signed   = r_div_signed;
    assign bus.muldiv_rs1   = r_rs1;
    assign bus.muldiv_rs2   = r_rs2;
    assign bus.muldiv_flush = bus.flush;
    assign bus.wb_valid     = (r_state == S_RESP);
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_rd        = r_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_funct3     <= 3'b000;
            r_is_w       <= 1'b0;
            r_rs1        <= 64'h0;
            r_rs2        <= 64'h0;
            r_rd         <= '0;
            r_mul_signed <= 2'b00;
            r_div_signed <= 1'b0;
            r_wb_data    <= 64'h0;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.op_valid) begin
                        r_funct3     <= w_f3_eff;
                        r_is_w       <= bus.op_is_w;
                        r_rs1        <= bus.op_rs1;
                        r_rs2        <= bus.op_rs2;
                        r_rd         <= bus.op_rd;
                        r_div_signed <= w_f3_eff[2] & ~w_f3_eff[0];
                        if (w_f3_eff[2])
                            r_mul_signed <= 2'b00;
                        else if (w_f3_eff[1:0] == 2'b10)
                            r_mul_signed <= 2'b10;
                        else if (w_f3_eff[1:0] == 2'b11)
                            r_mul_signed <= 2'b00;
                        else
                            r_mul_signed <= 2'b11;
                        if (w_special) begin
                            r_wb_data <= w_special_data;
                            r_state   <= S_RESP;
                        end else begin
                            r_state   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: if (bus.muldiv_ready) r_state <= S_BUSY;
                S_BUSY: begin
                    if (bus.out_valid) begin
                        r_wb_data <= w_unit_data;
                        r_state   <= S_RESP;
                    end
                end
                S_RESP: if (bus.wb_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl: the bench plays pipeline, unit and writeback,
// feeding hand-computed unit results and checking the architectural outputs.
module tb_muldiv_issue_ctrl;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    muldiv_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    muldiv_issue_ctrl #(.TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Presents an op in the current cycle; it is taken at the next edge.
    task automatic present(input logic [2:0] f3, input logic w, input logic [63:0] a,
                           input logic [63:0] b, input logic [TAG_W-1:0] rd);
        bus.op_valid  = 1'b1;
        bus.op_funct3 = f3;
        bus.op_is_w   = w;
        bus.op_rs1    = a;
        bus.op_rs2    = b;
        bus.op_rd     = rd;
        #1;
        chk("accept_op_ready", {63'h0, bus.op_ready}, 64'h1);
        cyc();
        bus.op_valid = 1'b0;
        #1;
    endtask

    task automatic unit_pulse(input logic [63:0] hi, input logic [63:0] lo,
                              input logic [63:0] q, input logic [63:0] r);
        bus.out_valid = 1'b1;
        bus.result_hi = hi;
        bus.result_lo = lo;
        bus.quotient  = q;
        bus.remainder = r;
        #1;
        chk("no_wb_during_out_valid", {63'h0, bus.wb_valid}, 64'h0);
        cyc();
        bus.out_valid = 1'b0;
        #1;
    endtask

    task automatic retire(input string tag, input logic [63:0] data, input logic [TAG_W-1:0] rd);
        chk({tag, "_wb_valid"}, {63'h0, bus.wb_valid}, 64'h1);
        chk({tag, "_wb_data"}, bus.wb_data, data);
        chk({tag, "_wb_rd"}, {59'h0, bus.wb_rd}, {59'h0, rd});
        bus.wb_ready = 1'b1;
        cyc();
        bus.wb_ready = 1'b0;
        #1;
        chk({tag, "_wb_drop"}, {63'h0, bus.wb_valid}, 64'h0);
        chk({tag, "_idle_ready"}, {63'h0, bus.op_ready}, 64'h1);
    endtask

    initial begin
        bus.op_valid = 0; bus.op_funct3 = 0; bus.op_is_w = 0; bus.op_rs1 = 0; bus.op_rs2 = 0;
        bus.op_rd = 0; bus.flush = 0; bus.muldiv_ready = 1; bus.out_valid = 0;
        bus.result_hi = 0; bus.result_lo = 0; bus.quotient = 0; bus.remainder = 0; bus.wb_ready = 0;

        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_op_ready", {63'h0, bus.op_ready}, 64'h1);
        chk("rst_wb_valid", {63'h0, bus.wb_valid}, 64'h0);
        chk("rst_wb_data", bus.wb_data, 64'h0);
        chk("rst_rs1", bus.muldiv_rs1, 64'h0);
        chk("rst_rs2", bus.muldiv_rs2, 64'h0);
        chk("rst_start", {62'h0, bus.mul_valid, bus.div_valid}, 64'h0);
        chk("rst_ctrl", {60'h0, bus.mul_signed, bus.div_signed, bus.muldivw}, 64'h0);

        // MULHU all-ones * 2 = 0x1_FFFF_FFFF_FFFF_FFFE
        present(3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 5'd3);
        chk("mulhu_mul_valid", {63'h0, bus.mul_valid}, 64'h1);
        chk("mulhu_div_valid", {63'h0, bus.div_valid}, 64'h0);
        chk("mulhu_mul_signed", {62'h0, bus.mul_signed}, 64'h0);
        chk("mulhu_rs1", bus.muldiv_rs1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("mulhu_rs2", bus.muldiv_rs2, 64'h2);
        cyc();
        chk("mulhu_pulse_once", {63'h0, bus.mul_valid}, 64'h0);
        unit_pulse(64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h0);
        retire("mulhu", 64'h1, 5'd3);

        // MULW 0x7FFFFFFF * 2, unit held busy for one cycle first
        bus.muldiv_ready = 1'b0;
        present(3'b000, 1'b1, 64'h7FFF_FFFF, 64'h2, 5'd4);
        chk("mulw_wait_ready", {63'h0, bus.mul_valid}, 64'h0);
        cyc();
        bus.muldiv_ready = 1'b1;
        #1;
        chk("mulw_mul_valid", {63'h0, bus.mul_valid}, 64'h1);
        chk("mulw_muldivw", {63'h0, bus.muldivw}, 64'h1);
        chk("mulw_mul_signed", {62'h0, bus.mul_signed}, 64'h3);
        cyc();
        chk("mulw_muldivw_busy", {63'h0, bus.muldivw}, 64'h1);
        unit_pulse(64'h0, 64'h0000_0000_FFFF_FFFE, 64'h0, 64'h0);
        retire("mulw", 64'hFFFF_FFFF_FFFF_FFFE, 5'd4);

        // DIVW / REMW by zero resolved locally
        bus.op_valid = 1'b1; bus.op_funct3 = 3'b100; bus.op_is_w = 1'b1;
        bus.op_rs1 = 64'h8000_0005; bus.op_rs2 = 64'h0; bus.op_rd = 5'd5;
        #1;
        chk("divw0_no_start_T", {62'h0, bus.mul_valid, bus.div_valid}, 64'h0);
        cyc();
        bus.op_valid = 1'b0;
        #1;
        chk("divw0_no_start_T1", {62'h0, bus.mul_valid, bus.div_valid}, 64'h0);
        retire("divw0", 64'hFFFF_FFFF_FFFF_FFFF, 5'd5);
        present(3'b110, 1'b1, 64'h8000_0005, 64'h0, 5'd6);
        chk("remw0_no_start", {63'h0, bus.div_valid}, 64'h0);
        retire("remw0", 64'hFFFF_FFFF_8000_0005, 5'd6);

        // Signed overflow DIV / REM
        present(3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7);
        chk("divovf_no_start", {63'h0, bus.div_valid}, 64'h0);
        retire("divovf", 64'h8000_0000_0000_0000, 5'd7);
        present(3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8);
        retire("removf", 64'h0, 5'd8);

        // REMW -7 % 2 = -1, writeback stalled 5 cycles; stray out_valid in RESP ignored
        present(3'b110, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'h2, 5'd9);
        chk("remw_div_valid", {63'h0, bus.div_valid}, 64'h1);
        chk("remw_mul_valid", {63'h0, bus.mul_valid}, 64'h0);
        chk("remw_div_signed", {63'h0, bus.div_signed}, 64'h1);
        cyc();
        unit_pulse(64'h0, 64'h0, 64'h0000_0000_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF);
        bus.op_valid = 1'b1; bus.op_funct3 = 3'b000; bus.op_is_w = 1'b0;
        bus.out_valid = 1'b1; bus.remainder = 64'h1234;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_wb_valid", {63'h0, bus.wb_valid}, 64'h1);
            chk("stall_wb_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
            chk("stall_wb_rd", {59'h0, bus.wb_rd}, 64'd9);
            chk("stall_op_ready", {63'h0, bus.op_ready}, 64'h0);
            cyc();
        end
        bus.op_valid = 1'b0; bus.out_valid = 1'b0;
        #1;
        retire("remw", 64'hFFFF_FFFF_FFFF_FFFF, 5'd9);

        // Flush during BUSY of a 64-bit DIV
        present(3'b100, 1'b0, 64'd100, 64'd7, 5'd10);
        chk("div_start", {63'h0, bus.div_valid}, 64'h1);
        cyc();
        bus.flush = 1'b1;
        #1;
        chk("flush_passthru", {63'h0, bus.muldiv_flush}, 64'h1);
        chk("flush_op_ready", {63'h0, bus.op_ready}, 64'h0);
        cyc();
        bus.flush = 1'b0;
        bus.out_valid = 1'b1; bus.quotient = 64'd14; bus.remainder = 64'd2;
        #1;
        chk("flush_release", {63'h0, bus.muldiv_flush}, 64'h0);
        chk("flush_op_ready_next", {63'h0, bus.op_ready}, 64'h1);
        chk("flush_no_wb", {63'h0, bus.wb_valid}, 64'h0);
        cyc();
        bus.out_valid = 1'b0;
        #1;
        chk("flush_late_pulse_ignored", {63'h0, bus.wb_valid}, 64'h0);

        // MUL 3*4 after the flush
        present(3'b000, 1'b0, 64'd3, 64'd4, 5'd11);
        chk("mul_mul_valid", {63'h0, bus.mul_valid}, 64'h1);
        chk("mul_mul_signed", {62'h0, bus.mul_signed}, 64'h3);
        cyc();
        unit_pulse(64'h0, 64'd12, 64'h0, 64'h0);
        retire("mul", 64'd12, 5'd11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
